// File: rtl/aes_iter_core_if.sv
// aes_iter_core_if: request/response handshake bundle for aes_iter_core.
// master is the block source/sink side, slave is the core.
interface aes_iter_core_if #(
  parameter int KEY_BITS = 128
) ();
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_block;
  logic [KEY_BITS-1:0] in_key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_block;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block
  );
endinterface

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/256 encryptor, one round per clock,
// key schedule expanded on the fly. Define AES_DBG_EN for debug ports.
module aes_iter_core #(
  parameter int KEY_BITS = 128
) (
  input  logic           clk,
  input  logic           reset,
  aes_iter_core_if.slave bus,
  output logic           busy
`ifdef AES_DBG_EN
  ,
  output logic [3:0]     dbg_round,
  output logic [1:0]     dbg_state
`endif
);

  localparam logic [3:0] NR = (KEY_BITS == 256) ? 4'd14 : 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rotw(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Word chaining shared by both schedules: w0 = p0^t, wi = pi^w(i-1).
  function automatic logic [127:0] next_grp(input logic [127:0] p,
                                            input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          round_q, round_d;
  logic [127:0]        blk_q, blk_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [127:0]        sr, mc, rk, round_out;
  logic [KEY_BITS-1:0] key_nxt;
  logic                last;

  assign last = (round_q == NR);

  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] =
          sbox(blk_q[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
    end
    round_out = (last ? sr : mc) ^ rk;
  end

  if (KEY_BITS == 128) begin : g_k128
    logic [31:0] t;
    always_comb begin
      t = subw(rotw(key_q[31:0])) ^ {rcon(round_q), 24'h0};
      rk = next_grp(key_q, t);
      key_nxt = rk;
    end
  end else if (KEY_BITS == 256) begin : g_k256
    // key_q is the {kA,kB} window; round 1 uses kB unchanged.
    logic [31:0]  w, t;
    logic [127:0] grp;
    always_comb begin
      w = key_q[31:0];
      t = subw(round_q[0] ? w : rotw(w));
      if (!round_q[0]) t = t ^ {rcon(round_q >> 1), 24'h0};
      grp = next_grp(key_q[255:128], t);
      if (round_q == 4'd1) begin
        rk = key_q[127:0];
        key_nxt = key_q;
      end else begin
        rk = grp;
        key_nxt = {key_q[127:0], grp};
      end
    end
  end else begin : g_bad
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    blk_d       = blk_q;
    key_d       = key_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ROUND;
          round_d = 4'd1;
          blk_d   = bus.in_block ^ bus.in_key[KEY_BITS-1 -: 128];
          key_d   = bus.in_key;
          busy_d  = 1'b1;
        end
      end
      ROUND: begin
        blk_d   = round_out;
        key_d   = key_nxt;
        round_d = round_q + 4'd1;
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          round_d     = 4'd0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      round_q     <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = blk_q;
  assign busy          = busy_q;

`ifdef AES_DBG_EN
  assign dbg_round = round_q;
  assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: drives AES-128 and AES-256 instances with directed
// and random requests, checked against an FIPS-197 style reference model.
module tb_aes_iter_core;

  logic clk = 1'b0;
  logic reset;
  logic busy128, busy256;

  always #5 clk = ~clk;

  aes_iter_core_if #(.KEY_BITS(128)) if128 ();
  aes_iter_core_if #(.KEY_BITS(256)) if256 ();

`ifdef AES_DBG_EN
  logic [3:0] dr128, dr256;
  logic [1:0] ds128, ds256;
`endif

  aes_iter_core #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(reset), .bus(if128), .busy(busy128)
`ifdef AES_DBG_EN
    , .dbg_round(dr128), .dbg_state(ds128)
`endif
  );

  aes_iter_core #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(reset), .bus(if256), .busy(busy256)
`ifdef AES_DBG_EN
    , .dbg_round(dr256), .dbg_state(ds256)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: S-box derived from GF(2^8) inverse + affine map.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
              ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw_m(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] mcoef(input int r, input int k);
    case ((k - r + 4) % 4)
      0: return 8'h02;
      1: return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  // Key occupies the low 32*nk bits of key.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                           input logic [255:0] key,
                                           input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*nk-1-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw_m(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < nr) begin
            s[r][c] = 8'h00;
            for (int k = 0; k < 4; k++) s[r][c] ^= gmul(mcoef(r, k), t[k][c]);
          end else begin
            s[r][c] = t[r][c];
          end
          s[r][c] ^= w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic ir(input bit s);
    return s ? if256.in_ready : if128.in_ready;
  endfunction
  function automatic logic ov(input bit s);
    return s ? if256.out_valid : if128.out_valid;
  endfunction
  function automatic logic [127:0] ob(input bit s);
    return s ? if256.out_block : if128.out_block;
  endfunction
  function automatic logic bz(input bit s);
    return s ? busy256 : busy128;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [127:0] pt,
                       input logic [255:0] key);
    if (s) begin
      if256.in_valid = v;
      if256.in_block = pt;
      if256.in_key   = key;
    end else begin
      if128.in_valid = v;
      if128.in_block = pt;
      if128.in_key   = key[127:0];
    end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) if256.out_ready = v;
    else   if128.out_ready = v;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input bit s, input logic [127:0] pt,
                      input logic [255:0] key, input string tag);
    int n;
    n = 0;
    drive(s, 1'b1, pt, key);
    while (!ir(s) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 128'(ir(s)), 128'd1);
    @(negedge clk);
    drive(s, 1'b0, pt, key);
  endtask

  // The accept edge counts as edge 1.
  task automatic wait_out(input bit s, input logic [127:0] exp,
                          input string tag, input bit churn);
    int n;
    n = 1;
    while (!ov(s) && n < 64) begin
      if (churn) drive(s, 1'b0, rnd128(), {rnd128(), rnd128()});
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(s ? 15 : 11));
    chk({tag, "_ct"}, ob(s), exp);
    chk({tag, "_busy"}, 128'(bz(s)), 128'd1);
  endtask

  task automatic consume(input bit s, input string tag);
    set_ordy(s, 1'b1);
    @(negedge clk);
    set_ordy(s, 1'b0);
    chk({tag, "_ov0"}, 128'(ov(s)), 128'd0);
    chk({tag, "_ir1"}, 128'(ir(s)), 128'd1);
    chk({tag, "_busy0"}, 128'(bz(s)), 128'd0);
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] pt, exp;
    logic [255:0] key;
    int first, second, stale;

    build_sbox();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    set_ordy(1'b0, 1'b0);
    set_ordy(1'b1, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ir", 128'(ir(s[0])), 128'd1);
      chk("rst_ov", 128'(ov(s[0])), 128'd0);
      chk("rst_ob", ob(s[0]), 128'd0);
      chk("rst_busy", 128'(bz(s[0])), 128'd0);
    end
`ifdef AES_DBG_EN
    chk("rst_dbg_round", 128'(dr128), 128'd0);
    chk("rst_dbg_state", 128'(ds256), 128'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    send(1'b0, P1, K1, "v128a");
    wait_out(1'b0, C1, "v128a", 1'b0);
    consume(1'b0, "v128a");
    send(1'b0, P2, K2, "v128b");
    wait_out(1'b0, C2, "v128b", 1'b0);
    consume(1'b0, "v128b");
    send(1'b1, P1, K3, "v256");
    wait_out(1'b1, C3, "v256", 1'b0);
    consume(1'b1, "v256");

    // Backpressure with a second request waiting.
    send(1'b0, P2, K2, "bp");
    wait_out(1'b0, C2, "bp", 1'b0);
    drive(1'b0, 1'b1, P1, K1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_ov", 128'(ov(1'b0)), 128'd1);
      chk("bp_hold_ob", ob(1'b0), C2);
      chk("bp_hold_ir", 128'(ir(1'b0)), 128'd0);
    end
    set_ordy(1'b0, 1'b1);
    @(negedge clk);
    set_ordy(1'b0, 1'b0);
    chk("bp_idle_ir", 128'(ir(1'b0)), 128'd1);
    chk("bp_idle_ov", 128'(ov(1'b0)), 128'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, P1, K1);
    wait_out(1'b0, C1, "bp2", 1'b0);
    consume(1'b0, "bp2");

    send(1'b0, P1, K1, "churn128");
    wait_out(1'b0, C1, "churn128", 1'b1);
    consume(1'b0, "churn128");
    send(1'b1, P1, K3, "churn256");
    wait_out(1'b1, C3, "churn256", 1'b1);
    consume(1'b1, "churn256");

    for (int i = 0; i < 6; i++) begin
      pt  = rnd128();
      key = {rnd128(), rnd128()};
      exp = aes_ref(pt, {128'h0, key[127:0]}, 4);
      send(1'b0, pt, key, "rnd128");
      wait_out(1'b0, exp, "rnd128", 1'b0);
      consume(1'b0, "rnd128");
      exp = aes_ref(pt, key, 8);
      send(1'b1, pt, key, "rnd256");
      wait_out(1'b1, exp, "rnd256", 1'b0);
      consume(1'b1, "rnd256");
    end

    // Throughput with out_ready and in_valid held high.
    set_ordy(1'b0, 1'b1);
    drive(1'b0, 1'b1, P2, K2);
    first = -1;
    second = -1;
    for (int t = 0; t < 60 && second < 0; t++) begin
      @(negedge clk);
      if (ov(1'b0)) begin
        if (first < 0) begin
          first = t;
          chk("tp_ct0", ob(1'b0), C2);
        end else begin
          second = t;
          chk("tp_ct1", ob(1'b0), C2);
        end
      end
    end
    drive(1'b0, 1'b0, P2, K2);
    @(negedge clk);
    set_ordy(1'b0, 1'b0);
    chk("tp_gap", 128'(second - first), 128'd12);
    chk("tp_ir", 128'(ir(1'b0)), 128'd1);

    // Reset in the middle of round 5.
    send(1'b0, P2, K2, "rst");
    repeat (4) @(negedge clk);
`ifdef AES_DBG_EN
    chk("rst_mid_dbg_round", 128'(dr128), 128'd5);
    chk("rst_mid_dbg_state", 128'(ds128), 128'd1);
`endif
    reset = 1'b0;
    #1;
    chk("rst_mid_ov", 128'(ov(1'b0)), 128'd0);
    chk("rst_mid_ob", ob(1'b0), 128'd0);
    chk("rst_mid_ir", 128'(ir(1'b0)), 128'd1);
    chk("rst_mid_busy", 128'(bz(1'b0)), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov(1'b0) || bz(1'b0)) stale++;
    end
    chk("rst_stale", 128'(stale), 128'd0);
    send(1'b0, P2, K2, "post_rst");
    wait_out(1'b0, C2, "post_rst", 1'b0);
    consume(1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_iter_core.md
# aes_iter_core

Parametrised iterative AES encryption core that completes one cipher round per clock. It supports AES-128 or AES-256, selected at elaboration, and expands the key schedule on the fly, so only one round key is held at a time. It sits between the block-source and block-sink stages of the crypto datapath and uses valid/ready handshakes on both sides. It replaces the fixed-width, unhandshaked AES-128 round engine.

## Interface
Parameters:
- KEY_BITS, default 128: key length. Legal values are 128 and 256; any other value is an elaboration error. NR = 10 for 128, 14 for 256.

Ports (all widths in bits):
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- in_valid, input, 1: request carries a plaintext block and key.
- in_ready, output, 1: core can accept a request.
- in_block, input, 128: plaintext. [127:120] is state byte s(0,0); 32-bit columns are ordered MSB first.
- in_key, input, KEY_BITS: cipher key, same byte ordering as in_block.
- out_valid, output, 1: ciphertext is valid.
- out_ready, input, 1: sink accepts the ciphertext.
- out_block, output, 128: ciphertext.
- busy, output, 1: high in ROUND or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - ROUND: rounds in progress.
  - DONE: out_valid=1.
- IDLE -> ROUND on in_valid&&in_ready (the accept edge). On that edge:
  - state <= in_block ^ in_key[KEY_BITS-1 -: 128];
  - key registers load in_key;
  - round <= 1.
- ROUND, each cycle:
  - state <= ARK(MC(SR(SB(state))), rk[round]).
  - MC is bypassed when round==NR.
  - round increments each cycle; on the round==NR edge go to DONE.
- DONE -> IDLE on out_ready. out_block is held stable until that handshake.
- Key schedule for AES-128:
  - rk[r] = expand(rk[r-1], rcon[r]);
  - RotWord then SubWord then rcon, all on the last word;
  - rcon sequence 01,02,04,08,10,20,40,80,1b,36.
- Key schedule for AES-256:
  - Keep a window {kA,kB}. After the accept edge, kA = key[255:128] and kB = key[127:0].
  - rk[1] = kB.
  - For r>=2, the new 128-bit group is derived from kA and the last word of kB:
    - even r: RotWord+SubWord+rcon[r/2];
    - odd r: SubWord only.
  - The window then shifts: {kA,kB} <= {kB,new}, and rk[r] = new.
- The S-box is the standard FIPS-197 forward table. 16 lookups are used for state bytes and 4 for key-schedule words, all in the same cycle.
- in_block and in_key are sampled only on the accept edge. Later changes to them have no effect.
- in_valid while not IDLE is ignored and not accepted; the source must hold the request.

## Timing
- Reset values: in_ready=1, out_valid=0, out_block=0, busy=0, state IDLE, round=0, key and state registers 0.
- Latency: out_valid rises exactly NR+1 clock edges after the accept edge. That is 11 edges for AES-128 and 15 for AES-256.
- Throughput: with out_ready held high, the minimum spacing between accepts is NR+2 cycles, because there is one DONE cycle and then one IDLE cycle.
- in_ready is combinationally equal to (state==IDLE). There is no combinational path from in_valid or out_ready to any output.
- If out_ready is low in DONE, the core stalls indefinitely with out_valid=1 and out_block stable.
- Reset asserted mid-operation: all registers return to reset values immediately. The request in flight is dropped and never emitted. in_ready=1 on the first edge after reset deasserts.

## Configuration
- AES_DBG_EN
  - Defined: adds output ports dbg_round[3:0] (the current round counter, 0 in IDLE) and dbg_state[1:0] (IDLE=0, ROUND=1, DONE=2). Both reset to 0.
  - Undefined: neither port exists, and datapath behaviour is identical.

## Test plan
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 edges after accept.
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- KEY_BITS=256, key 000102…1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, with out_valid 15 edges after accept.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_block is unchanged, in_ready stays 0, and a second in_valid is not accepted. Then pulse out_ready -> IDLE next edge, followed by a correct second result.
- Input churn: change in_block and in_key every cycle after the accept edge -> the result still matches the vector for the values sampled at accept.
- Reset at round 5 -> out_valid=0, out_block=0 and in_ready=1 immediately. No stale output appears, and the next request produces the correct ciphertext.
